scpu_hazard_unit: RTL
=====================

// Module: scpu_hazard_unit
// PURPOSE
//  Parametrised successor to the fixed one-cycle bubble control of the 8-bit pipelined core. It sits beside the ID stage.
//  It keeps a scoreboard of in-flight register writes and detects RAW hazards on both source operands.
//  It selects forwarding sources, or stalls when no source is ready, and flushes IF/ID on a taken branch.
//  Also provides a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  DATA_W   8  datapath width (forward-data ports only)
//  NREG     4  architectural registers; RA_W = $clog2(NREG)
//  DEPTH    3  scoreboard entries = stages after ID (0=ID/EXE, 1=EXE/DM, 2=DM/WB); >=2
//  FWD_EN   1  1: forwarding enabled; 0: stall until producer retires
//  CNT_W    16 stall counter width
// PORTS
//  clk            in   1            rising-edge clock
//  rst            in   1            synchronous, active-high reset
//  id_valid       in   1            ID holds a real instruction
//  id_rs1/id_rs2  in   RA_W         source register indices
//  id_use1/id_use2 in  1            source actually read
//  id_wr_en       in   1            ID instruction writes the register file
//  id_rd          in   RA_W         destination index
//  id_is_load     in   1            result comes from data memory
//  br_taken       in   1            branch in ID resolved taken this cycle
//  fwd_data       in   DEPTH*DATA_W per-entry result bus, entry i at [i*DATA_W +: DATA_W]
//  stall          out  1            hold PC and IF/ID, insert bubble into ID/EXE (pc_en = ~stall)
//  flush          out  1            squash IF/ID contents next edge
//  fwd_sel1/fwd_sel2 out $clog2(DEPTH+1) 0 = register file, i+1 = scoreboard entry i
//  fwd_val1/fwd_val2 out DATA_W     operand selected by fwd_sel (0 when sel=0)
//  stall_cnt      out  CNT_W        saturating count of stall cycles
// BEHAVIOUR
//  - Reset: all scoreboard entries invalid and stall_cnt = 0.
//    stall, flush and fwd_sel* are then 0, because they are combinational from the cleared state.
//  - Scoreboard entry: {v, rd, load}. Every clock, entry i moves to entry i+1 and the oldest entry drops out.
//    The pipeline after ID never stalls.
//  - Entry 0 load: when id_valid & ~stall & ~flush-kill, it takes {id_wr_en, id_rd, id_is_load}; otherwise a bubble (v=0).
//  - Register index 0 is not special. Every index is tracked.
//  - Matching, per used source s: pick the youngest valid entry with rd==s (smallest i).
//    Younger entries shadow older ones.
//  - Ready rule: entry i is ready if FWD_EN=1 and i >= LAT, where LAT = 2 for a load and 1 otherwise.
//  - FWD_EN=0: any match means not ready.
//  - No match: sel=0 and the register file value is used. The RF is not write-through.
//  - Match and ready: sel = i+1 and fwd_val = that entry's slice of fwd_data.
//  - Match and not ready: stall=1. Stall only counts when id_valid=1.
//  - stall, flush and fwd_* are purely combinational; there is no added latency.
//  - flush = br_taken & ~stall. If stall and br_taken are both asserted, stall wins.
//    In that case the branch stays in ID and is re-evaluated next cycle.
//  - On flush the ID instruction itself still issues into entry 0. Only the IF instruction is killed.
//  - stall_cnt increments on each clock with stall=1 and saturates at all-ones; it has no wrap.
//  - A reset asserted mid-stall clears everything on that edge.
//    The first cycle after reset sees an empty scoreboard.
// STRUCTURE
//  - Shared package scpu_pkg holds: the RA_W derivation function, FWD_RF = 0, and the LAT_ALU / LAT_LOAD constants.
//  - One sub-module, scpu_fwd_match, does the per-source priority match, ready check and mux.
//    It is instantiated twice (rs1, rs2).
//  - The scoreboard shift register and stall counter live in the top module.
// TESTING
//  - Reset with FWD_EN=1, DEPTH=3: hold rst 2 cycles.
//    -> stall=0, flush=0, sel1=sel2=0, stall_cnt=0.
//  - ALU back-to-back: issue ADD r1. Next cycle issue a use of rs1=r1.
//    -> cycle 2 stalls 1 (entry0, LAT=1).
//    -> cycle 3 sel1=2 and fwd_val1 = fwd_data[15:8] (e.g. 0x5A).
//  - Load-use: LD r2, then a use of rs2=r2.
//    -> 2 stall cycles, then sel2=3.
//    -> stall_cnt rises by 2.
//  - Shadowing: ADD r3 (result 0x11), then ADD r3 (result 0x22), then a use of r3.
//    -> the younger writer is selected, value 0x22, never 0x11.
//  - FWD_EN=0: ADD r1, then a use of r1.
//    -> 3 stall cycles (until the entry leaves DEPTH).
//    -> then sel1=0.
//  - Branch: br_taken=1 with no hazard -> flush=1 for one cycle.
//    br_taken=1 during a stall -> flush=0, branch held; flush=1 on the cycle the stall clears.
//    Counter saturation is checked with CNT_W=2: a 5-cycle stall -> stall_cnt=3.

Source files
------------

// File: rtl/scpu_pkg.sv
// Shared constants and helpers for the 8-bit pipelined core's
// hazard detection and forwarding logic.
package scpu_pkg;

  localparam int FWD_RF   = 0;
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  function automatic int ra_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/scpu_fwd_match.sv
// Per-source scoreboard match: youngest matching writer wins,
// then a ready check decides between forwarding and stalling.
module scpu_fwd_match
  import scpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                    used,
  input  logic [RA_W-1:0]         rs,
  input  logic [DEPTH-1:0]        ent_v,
  input  logic [DEPTH*RA_W-1:0]   ent_rd,
  input  logic [DEPTH-1:0]        ent_load,
  input  logic [DEPTH*DATA_W-1:0] fwd_data,
  output logic                    hazard,
  output logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       val
);

  logic hit;
  logic hit_load;
  int   idx;

  always_comb begin
    hazard   = 1'b0;
    sel      = SEL_W'(FWD_RF);
    val      = '0;
    hit      = 1'b0;
    hit_load = 1'b0;
    idx      = 0;
    // scan oldest to youngest so the youngest match is the last kept
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_v[i] && (ent_rd[i*RA_W +: RA_W] == rs)) begin
        hit      = 1'b1;
        hit_load = ent_load[i];
        idx      = i;
      end
    end
    if (used && hit) begin
      if ((FWD_EN != 0) &&
          (idx >= (hit_load ? LAT_LOAD : LAT_ALU))) begin
        sel = SEL_W'(idx + 1);
        val = fwd_data[idx*DATA_W +: DATA_W];
      end else begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scpu_hazard_unit.sv
// Scoreboard-based RAW hazard unit: forwarding select, stall,
// branch flush and a saturating stall-cycle counter.
module scpu_hazard_unit
  import scpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16,
  localparam int RA_W  = ra_w(NREG),
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [RA_W-1:0]         id_rs1,
  input  logic [RA_W-1:0]         id_rs2,
  input  logic                    id_use1,
  input  logic                    id_use2,
  input  logic                    id_wr_en,
  input  logic [RA_W-1:0]         id_rd,
  input  logic                    id_is_load,
  input  logic                    br_taken,
  input  logic [DEPTH*DATA_W-1:0] fwd_data,
  output logic                    stall,
  output logic                    flush,
  output logic [SEL_W-1:0]        fwd_sel1,
  output logic [SEL_W-1:0]        fwd_sel2,
  output logic [DATA_W-1:0]       fwd_val1,
  output logic [DATA_W-1:0]       fwd_val2,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic [DEPTH-1:0]      sb_v;
  logic [DEPTH-1:0]      sb_load;
  logic [DEPTH*RA_W-1:0] sb_rd;
  logic                  haz1;
  logic                  haz2;
  logic                  issue;

  assign stall = id_valid & (haz1 | haz2);
  assign flush = br_taken & ~stall;
  // a flushed branch still issues; only the IF slot is killed
  assign issue = id_valid & ~stall;

  scpu_fwd_match #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W),
    .DEPTH  (DEPTH),
    .FWD_EN (FWD_EN)
  ) u_m1 (
    .used     (id_use1),
    .rs       (id_rs1),
    .ent_v    (sb_v),
    .ent_rd   (sb_rd),
    .ent_load (sb_load),
    .fwd_data (fwd_data),
    .hazard   (haz1),
    .sel      (fwd_sel1),
    .val      (fwd_val1)
  );

  scpu_fwd_match #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W),
    .DEPTH  (DEPTH),
    .FWD_EN (FWD_EN)
  ) u_m2 (
    .used     (id_use2),
    .rs       (id_rs2),
    .ent_v    (sb_v),
    .ent_rd   (sb_rd),
    .ent_load (sb_load),
    .fwd_data (fwd_data),
    .hazard   (haz2),
    .sel      (fwd_sel2),
    .val      (fwd_val2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v    <= '0;
      sb_load <= '0;
      sb_rd   <= '0;
    end else begin
      sb_v    <= {sb_v[DEPTH-2:0], issue & id_wr_en};
      sb_load <= {sb_load[DEPTH-2:0], id_is_load};
      sb_rd   <= {sb_rd[(DEPTH-1)*RA_W-1:0], id_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
